motor_drive_sequencer: RTL

//  Downstream of the six-lane PWM generator. Selects the right/left PWM lanes for the commanded drive

---
 rtl/motor_pkg.sv | 70 +++++++
 rtl/fault_filter.sv | 48 ++++
 rtl/motor_drive_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - mode, direction, state and lane definitions for the motor drive sequencer
package motor_pkg;

    typedef enum logic [2:0] {
        MODE_STOP  = 3'd0,
        MODE_FWD   = 3'd1,
        MODE_RIGHT = 3'd2,
        MODE_LEFT  = 3'd3,
        MODE_REV   = 3'd4
    } mode_e;

    // Direction codes are the {in1, in2} bridge pin pair.
    typedef enum logic [1:0] {
        DIR_OFF = 2'b00,
        DIR_FWD = 2'b10,
        DIR_REV = 2'b01
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DEAD,
        ST_FAULT
    } state_e;

    // Bit positions within pwm_lanes = {L_L, R_L, L_R, R_R, L_F, R_F}.
    localparam logic [2:0] LANE_R_F = 3'd0;
    localparam logic [2:0] LANE_L_F = 3'd1;
    localparam logic [2:0] LANE_R_R = 3'd2;
    localparam logic [2:0] LANE_L_R = 3'd3;
    localparam logic [2:0] LANE_R_L = 3'd4;
    localparam logic [2:0] LANE_L_L = 3'd5;

    // Unused request codes 5-7 collapse to STOP.
    function automatic mode_e norm_mode(input logic [2:0] raw);
        case (raw)
            3'd1:    return MODE_FWD;
            3'd2:    return MODE_RIGHT;
            3'd3:    return MODE_LEFT;
            3'd4:    return MODE_REV;
            default: return MODE_STOP;
        endcase
    endfunction

    // RIGHT/LEFT are differential-speed turns, so both wheels still run forward.
    function automatic dir_e mode_dir(input mode_e m);
        case (m)
            MODE_FWD, MODE_RIGHT, MODE_LEFT: return DIR_FWD;
            MODE_REV:                        return DIR_REV;
            default:                         return DIR_OFF;
        endcase
    endfunction

    function automatic logic [2:0] lane_r(input mode_e m);
        case (m)
            MODE_RIGHT: return LANE_R_R;
            MODE_LEFT:  return LANE_R_L;
            default:    return LANE_R_F;
        endcase
    endfunction

    function automatic logic [2:0] lane_l(input mode_e m);
        case (m)
            MODE_RIGHT: return LANE_L_R;
            MODE_LEFT:  return LANE_L_L;
            default:    return LANE_L_F;
        endcase
    endfunction

endpackage

// File: rtl/fault_filter.sv
// rtl/fault_filter.sv - over-current flag synchronizer and consecutive-cycle trip filter
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   fault_i        : asynchronous over-current flag, active high
//   trip_o         : level, high while FILT_CYC consecutive synced-high cycles have been seen
//   sync_o         : synchronized fault_i level
module fault_filter #(
    parameter int FILT_CYC = 1_000,
    parameter int CNT_W    = 24
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic fault_i,
    output logic trip_o,
    output logic sync_o
);

    localparam logic [CNT_W-1:0] FILT = CNT_W'(FILT_CYC);

    logic             meta_q, sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any low synced cycle restarts the run; the count saturates at the trip value.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync_q) begin
            cnt_d = '0;
        end else if (cnt_q != FILT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= fault_i;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
        end
    end

    assign trip_o = (cnt_q == FILT);
    assign sync_o = sync_q;

endmodule

// File: rtl/motor_drive_sequencer.sv
// rtl/motor_drive_sequencer.sv - drive-mode sequencer for two H-bridges with dead-time and fault latch
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   pwm_lanes[5:0]        : {L_L,R_L,L_R,R_R,L_F,R_F} from the PWM generator
//   mode_req/valid/ready  : drive mode request handshake (0 STOP,1 FWD,2 RIGHT,3 LEFT,4 REV)
//   fault_in, fault_clr   : async over-current flag, single-cycle fault clear
//   en_r/en_l             : bridge enables (selected PWM lane, one clk late)
//   in1_*/in2_*           : direction pins, fwd 10, rev 01, off 00
//   active_mode, fault    : mode applied to the bridges, latched fault
module motor_drive_sequencer
    import motor_pkg::*;
#(
    parameter int DEADTIME_CYC   = 2_000_000,
    parameter int FAULT_FILT_CYC = 1_000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] pwm_lanes,
    input  logic [2:0] mode_req,
    input  logic       mode_valid,
    output logic       mode_ready,
    input  logic       fault_in,
    input  logic       fault_clr,
    output logic       en_r,
    output logic       en_l,
    output logic       in1_r,
    output logic       in2_r,
    output logic       in1_l,
    output logic       in2_l,
    output logic [2:0] active_mode,
    output logic       fault
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME_CYC - 1);

    state_e           state_q, state_d;
    mode_e            pend_q, pend_d;
    mode_e            mode_d;
    mode_e            active_mode_q;
    dir_e             dir_q;
    logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;
    logic             en_r_q, en_l_q, fault_q, ready_q;
    logic             trip, fault_sync, accept;
    mode_e            req;

    fault_filter #(
        .FILT_CYC (FAULT_FILT_CYC),
        .CNT_W    (CNT_W)
    ) u_fault_filter (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .fault_i  (fault_in),
        .trip_o   (trip),
        .sync_o   (fault_sync)
    );

    assign accept = mode_valid && ready_q;
    assign req    = norm_mode(mode_req);

    // mode_d is only meaningful when state_d is RUN; in RUN active_mode_q holds the running mode.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        dead_cnt_d = dead_cnt_q;
        mode_d     = active_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && req != MODE_STOP) begin
                    state_d = ST_RUN;
                    mode_d  = req;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (req == MODE_STOP) begin
                        state_d = ST_IDLE;
                    end else if (mode_dir(req) != mode_dir(active_mode_q)) begin
                        state_d    = ST_DEAD;
                        pend_d     = req;
                        dead_cnt_d = DEAD_LOAD;
                    end else begin
                        mode_d = req;
                    end
                end
            end
            ST_DEAD: begin
                if (dead_cnt_q == '0) begin
                    state_d = ST_RUN;
                    mode_d  = pend_q;
                end else begin
                    dead_cnt_d = dead_cnt_q - CNT_W'(1);
                end
            end
            ST_FAULT: begin
                if (fault_clr && !fault_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Trip overrides any accept or pending reversal in the same cycle.
        if (trip && state_q != ST_FAULT) begin
            state_d    = ST_FAULT;
            pend_d     = MODE_STOP;
            dead_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pend_q        <= MODE_STOP;
            dead_cnt_q    <= '0;
            active_mode_q <= MODE_STOP;
            dir_q         <= DIR_OFF;
            en_r_q        <= 1'b0;
            en_l_q        <= 1'b0;
            fault_q       <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            dead_cnt_q <= dead_cnt_d;
            fault_q    <= (state_d == ST_FAULT);
            ready_q    <= (state_d == ST_IDLE) || (state_d == ST_RUN);
            if (state_d == ST_RUN) begin
                active_mode_q <= mode_d;
                dir_q         <= mode_dir(mode_d);
                en_r_q        <= pwm_lanes[lane_r(mode_d)];
                en_l_q        <= pwm_lanes[lane_l(mode_d)];
            end else begin
                active_mode_q <= MODE_STOP;
                dir_q         <= DIR_OFF;
                en_r_q        <= 1'b0;
                en_l_q        <= 1'b0;
            end
        end
    end

    assign mode_ready  = ready_q;
    assign fault       = fault_q;
    assign active_mode = active_mode_q;
    assign en_r        = en_r_q;
    assign en_l        = en_l_q;
    assign in1_r       = dir_q[1];
    assign in2_r       = dir_q[0];
    assign in1_l       = dir_q[1];
    assign in2_l       = dir_q[0];

endmodule
